vsync_generator: RTL and testbench
==================================

Name: vsync_generator

Overview:
- Generates a synthetic active-low VSYNC at PAL (50 Hz) or NTSC (~60 Hz) frame rate from the 10 kHz system oscillator.
- It is the transmit-side counterpart of the SAVO MAX NTSC/PAL format detection path.
- Uses: test-pattern output, a fallback sync source when no video is present, and loopback self-test of format detection.
- Mode changes and stop requests take effect only at frame boundaries, so no runt frames are ever produced.

Parameters:
- PAL_PERIOD, 200, frame length in clk_10k ticks for PAL (20.0 ms).
- NTSC_PERIOD, 167, frame length in clk_10k ticks for NTSC (16.7 ms).
- PULSE_WIDTH, 2, VSYNC low time in ticks. Legal range 1..NTSC_PERIOD-1.
- Both periods must be ≤255 and >PULSE_WIDTH.

Ports:
- clk_10k  in  1  10 kHz free-running clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; sampled only in IDLE and at frame boundaries.
- pal_sel  in  1  1=PAL, 0=NTSC; sampled only at frame start.
- vsync_n  out  1  generated VSYNC, active low, registered.
- frame_start  out  1  one-cycle strobe, coincident with each vsync_n falling edge.
- field  out  1  field parity; 0 for the first frame after start, toggles every frame.
- mode_pal  out  1  mode latched for the current frame.
- frame_count  out  8  frames emitted since start; wraps 255→0.
- busy  out  1  1 while in SYNC or ACTIVE.

Behaviour:
- Reset (async, immediate): state=IDLE, tick_cnt=0, vsync_n=1, frame_start=0, field=0, mode_pal=0, frame_count=0, busy=0.
- Internal tick_cnt is 8 bits. Frame length is tick_cnt 0..P-1, where P = mode_pal ? PAL_PERIOD : NTSC_PERIOD.
- IDLE:
  - vsync_n=1, busy=0.
  - On an edge with enable=1: next state SYNC, tick_cnt=0, vsync_n=0, frame_start=1, mode_pal=pal_sel, field=0, frame_count=0.
  - Latency from enable seen high to vsync_n low is 1 edge.
- SYNC:
  - vsync_n=0, tick_cnt increments each edge.
  - At tick_cnt==PULSE_WIDTH-1: next state ACTIVE, vsync_n=1.
  - With PULSE_WIDTH=1, SYNC lasts exactly one cycle.
- ACTIVE:
  - vsync_n=1, tick_cnt increments.
  - At tick_cnt==P-1, if enable=1: next state SYNC, tick_cnt=0, vsync_n=0, frame_start=1, mode_pal=pal_sel, field toggles, frame_count+1 (mod 256).
  - At tick_cnt==P-1, if enable=0: next state IDLE, tick_cnt=0, vsync_n stays 1, no strobe. field, mode_pal and frame_count hold their values.
- Falling-edge to falling-edge spacing is exactly P cycles. Low time is exactly PULSE_WIDTH cycles.
- enable deasserted mid-frame: the current frame completes at full length with no truncation.
- enable re-asserted before the boundary: operation continues uninterrupted.
- pal_sel changing mid-frame: no effect until the next frame_start. mode_pal always reflects the length of the frame in progress.
- frame_start is high only in the first cycle of SYNC. It is never high in IDLE or ACTIVE.
- Glitches on enable or pal_sel between boundaries are ignored. Both inputs are synchronous to clk_10k; the caller is responsible for synchronising them.
- Illegal tick_cnt values (≥P, e.g. after an upset) are treated as end-of-frame at the next edge.

Test Plan:
- Reset; enable=1, pal_sel=1 → vsync_n falls 1 cycle later and stays low 2 cycles; falling edges every 200 cycles; frame_start single-cycle at each fall; mode_pal=1; field sequence 0,1,0,1.
- enable=1, pal_sel=0 → fall-to-fall spacing 167 cycles; mode_pal=0; frame_count increments 0,1,2… at each frame_start.
- PAL running, pal_sel→0 at tick 50 of frame N → frame N still 200 cycles; frame N+1 is 167 cycles; mode_pal changes in the same cycle as the frame N+1 frame_start.
- enable→0 at tick 10 of a PAL frame → vsync_n high through tick 199, then state IDLE, busy=0, no further frame_start. Re-enable → fall after 1 cycle with field=0 and frame_count=0.
- rst pulsed during SYNC (vsync_n=0) → vsync_n=1 and all outputs at reset values without a clock edge; operation resumes from IDLE after rst drops.
- 257 PAL frames → frame_count wraps 255→0 at frame 257; field is 0 in frame 257; spacing stays 200 throughout.

Source files
------------

// File: rtl/vsync_generator.sv
// Synthetic active-low VSYNC source at PAL or NTSC frame rate from the 10 kHz oscillator.
// Mode and run/stop requests are honoured only at frame boundaries, so frames are never truncated.
module vsync_generator #(
    parameter int PAL_PERIOD  = 200,
    parameter int NTSC_PERIOD = 167,
    parameter int PULSE_WIDTH = 2
) (
    input  logic       clk_10k,
    input  logic       rst,
    input  logic       enable,
    input  logic       pal_sel,
    output logic       vsync_n,
    output logic       frame_start,
    output logic       field,
    output logic       mode_pal,
    output logic [7:0] frame_count,
    output logic       busy
);

    localparam logic [7:0] PAL_LAST  = 8'(PAL_PERIOD - 1);
    localparam logic [7:0] NTSC_LAST = 8'(NTSC_PERIOD - 1);
    localparam logic [7:0] SYNC_LAST = 8'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE
    } state_t;

    state_t     state;
    logic [7:0] tick_cnt;
    logic [7:0] frame_last;
    logic       at_boundary;

    assign frame_last  = mode_pal ? PAL_LAST : NTSC_LAST;
    // Out-of-range counts (e.g. after an upset) also end the frame.
    assign at_boundary = (state != IDLE) && (tick_cnt >= frame_last);

    always_ff @(posedge clk_10k or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= 8'd0;
            vsync_n     <= 1'b1;
            frame_start <= 1'b0;
            field       <= 1'b0;
            mode_pal    <= 1'b0;
            frame_count <= 8'd0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (state == IDLE) begin
                tick_cnt <= 8'd0;
                vsync_n  <= 1'b1;
                busy     <= 1'b0;
                if (enable) begin
                    state       <= SYNC;
                    vsync_n     <= 1'b0;
                    frame_start <= 1'b1;
                    mode_pal    <= pal_sel;
                    field       <= 1'b0;
                    frame_count <= 8'd0;
                    busy        <= 1'b1;
                end
            end else if (at_boundary) begin
                tick_cnt <= 8'd0;
                if (enable) begin
                    state       <= SYNC;
                    vsync_n     <= 1'b0;
                    frame_start <= 1'b1;
                    mode_pal    <= pal_sel;
                    field       <= ~field;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    state   <= IDLE;
                    vsync_n <= 1'b1;
                    busy    <= 1'b0;
                end
            end else begin
                tick_cnt <= tick_cnt + 8'd1;
                case (state)
                    SYNC: begin
                        if (tick_cnt >= SYNC_LAST) begin
                            state   <= ACTIVE;
                            vsync_n <= 1'b1;
                        end
                    end
                    ACTIVE: vsync_n <= 1'b1;
                    default: begin
                        state    <= IDLE;
                        tick_cnt <= 8'd0;
                        vsync_n  <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vsync_generator.sv
// Randomised bench for vsync_generator: stimulus pushes expected frame starts,
// a monitor pops and compares them whenever the DUT strobes frame_start.
module tb_vsync_generator;

    localparam int PAL_P  = 200;
    localparam int NTSC_P = 167;
    localparam int PW     = 2;

    logic       clk_10k = 1'b0;
    logic       rst;
    logic       enable;
    logic       pal_sel;
    logic       vsync_n;
    logic       frame_start;
    logic       field;
    logic       mode_pal;
    logic [7:0] frame_count;
    logic       busy;

    vsync_generator #(
        .PAL_PERIOD (PAL_P),
        .NTSC_PERIOD(NTSC_P),
        .PULSE_WIDTH(PW)
    ) dut (
        .clk_10k    (clk_10k),
        .rst        (rst),
        .enable     (enable),
        .pal_sel    (pal_sel),
        .vsync_n    (vsync_n),
        .frame_start(frame_start),
        .field      (field),
        .mode_pal   (mode_pal),
        .frame_count(frame_count),
        .busy       (busy)
    );

    always #5 clk_10k = ~clk_10k;

    int unsigned cyc = 0;
    always @(posedge clk_10k) cyc <= cyc + 1;

    typedef struct {
        int unsigned at_cyc;
        bit          mode;
        bit          fld;
        logic [7:0]  count;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b1;
    bit          exp_field;
    logic [7:0]  exp_count;
    bit          cur_mode;
    int unsigned next_start;

    function automatic int period(input bit m);
        return m ? PAL_P : NTSC_P;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: frame-level scoreboard plus pulse-shape checks.
    initial begin : monitor
        bit prev_v = 1'b1;
        int low_len = 0;
        exp_t e;
        forever begin
            @(negedge clk_10k);
            if (mon_en) begin
                if (frame_start) begin
                    if (q.size() == 0) begin
                        chk("spurious_frame_start", frame_start, 0);
                    end else begin
                        e = q.pop_front();
                        chk("start_cycle", cyc, e.at_cyc);
                        chk("mode_pal", mode_pal, e.mode);
                        chk("field", field, e.fld);
                        chk("frame_count", frame_count, e.count);
                        chk("vsync_low_at_start", vsync_n, 0);
                        $display("frame cyc=%0d mode_pal=%0d field=%0d count=%0d",
                                 cyc, mode_pal, field, frame_count);
                    end
                end
                if (!vsync_n && prev_v) chk("fall_has_strobe", frame_start, 1);
                if (!vsync_n) chk("busy_while_low", busy, 1);
                if (vsync_n && !prev_v) chk("pulse_width", low_len, PW);
                low_len = vsync_n ? 0 : low_len + 1;
            end else begin
                low_len = 0;
            end
            prev_v = vsync_n;
        end
    end

    task automatic start_run(input bit p);
        enable     = 1'b1;
        pal_sel    = p;
        exp_field  = 1'b0;
        exp_count  = 8'd0;
        cur_mode   = p;
        q.push_back('{cyc + 1, p, 1'b0, 8'd0});
        next_start = cyc + 1 + period(p);
    endtask

    task automatic stop_check();
        @(negedge clk_10k);
        chk("idle_busy", busy, 0);
        chk("idle_vsync", vsync_n, 1);
        chk("idle_field_hold", field, exp_field);
        chk("idle_count_hold", frame_count, exp_count);
        chk("idle_mode_hold", mode_pal, cur_mode);
        chk("queue_drained", q.size(), 0);
        repeat ($urandom_range(2, 10)) begin
            @(negedge clk_10k);
            pal_sel = 1'($urandom);
        end
        chk("still_idle", busy, 0);
    endtask

    task automatic run_frames(input int n, input int drop_pct, input bit rnd_mode, input bit fixed_mode);
        bit en;
        bit p;
        for (int f = 0; f < n; f++) begin
            while (cyc < next_start - 1) begin
                @(negedge clk_10k);
                if (cyc < next_start - 1) begin
                    if ($urandom_range(0, 7) == 0) pal_sel = 1'($urandom);
                    if ($urandom_range(0, 7) == 0) enable = 1'($urandom);
                end
            end
            en      = ($urandom_range(0, 99) >= drop_pct);
            p       = rnd_mode ? 1'($urandom) : fixed_mode;
            enable  = en;
            pal_sel = p;
            if (!en) begin
                stop_check();
                return;
            end
            exp_field = ~exp_field;
            exp_count = exp_count + 8'd1;
            cur_mode  = p;
            q.push_back('{next_start, p, exp_field, exp_count});
            next_start = next_start + period(p);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_vsync_n"}, vsync_n, 1);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_field"}, field, 0);
        chk({tag, "_mode_pal"}, mode_pal, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin : stimulus
        rst     = 1'b1;
        enable  = 1'b0;
        pal_sel = 1'b0;
        #2;
        check_reset_values("reset");
        @(negedge clk_10k);
        rst = 1'b0;
        repeat (3) @(negedge clk_10k);
        chk("post_reset_idle", busy, 0);

        // Random runs: random mode per frame, mid-frame glitches, then stop at a boundary.
        for (int r = 0; r < 6; r++) begin
            start_run(1'($urandom));
            run_frames($urandom_range(2, 5), 0, 1'b1, 1'b0);
            run_frames(1, 100, 1'b1, 1'b0);
        end

        // Asynchronous reset while vsync_n is low.
        start_run(1'b0);
        run_frames(2, 0, 1'b0, 1'b0);
        @(negedge clk_10k);
        #2;
        chk("low_before_rst", vsync_n, 0);
        mon_en = 1'b0;
        q.delete();
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        enable = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk_10k);
        #1;
        chk("after_rst_idle", busy, 0);
        chk("after_rst_vsync", vsync_n, 1);
        mon_en = 1'b1;

        // 257 PAL frames: frame_count wraps to 0 and field is 0 on frame 257.
        start_run(1'b1);
        run_frames(256, 0, 1'b0, 1'b1);
        run_frames(1, 100, 1'b0, 1'b1);

        chk("final_queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
